// File: rtl/mean_inverse_filter_if.sv
// Stream bundle between the moving-average sum source and mean_inverse_filter.
// The master drives clear/in_valid/sum_in; the slave returns the reconstructed stream.
interface mean_inverse_filter_if #(
  parameter int unsigned DW = 24,
  parameter int unsigned SW = 30
);
  logic          clear;
  logic          in_valid;
  logic [SW-1:0] sum_in;
  logic          out_valid;
  logic [DW-1:0] data_out;
  logic          warm;
  logic          err;

  modport master (
    output clear,
    output in_valid,
    output sum_in,
    input  out_valid,
    input  data_out,
    input  warm,
    input  err
  );

  modport slave (
    input  clear,
    input  in_valid,
    input  sum_in,
    output out_valid,
    output data_out,
    output warm,
    output err
  );
endinterface

// File: rtl/mean_inverse_filter.sv
// Recovers x[n] from a length-N window sum: x[n] = S[n] - S[n-1] + x[n-N].
// Optional macro MIF_RANGE_CHECK_EN enables the sticky out-of-range err flag.
module mean_inverse_filter #(
  parameter int unsigned N  = 60,
  parameter int unsigned DW = 24,
  parameter int unsigned SW = 30
) (
  input logic                  clk,
  input logic                  rst,
  mean_inverse_filter_if.slave bus
);
  localparam int unsigned WPW = $clog2(N);
  localparam int unsigned FW  = $clog2(N + 1);

  logic [DW-1:0]  hist_q [N];
  logic [DW-1:0]  hist_wdata_d;
  logic [WPW-1:0] wp_q, wp_d;
  logic [SW-1:0]  sum_prev_q, sum_prev_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  data_out_q, data_out_d;
  logic           warm_q, warm_d;

  logic           accept;
  logic [DW-1:0]  old;
  logic [SW-1:0]  diff;
  logic [SW-1:0]  x_full;

  always_comb begin
    accept       = bus.in_valid & ~bus.clear;
    // Until the window has filled, the samples leaving it are the implied zeros.
    old          = (fill_q == FW'(N)) ? hist_q[wp_q] : '0;
    diff         = bus.sum_in - sum_prev_q;
    x_full       = diff + SW'(old);
    hist_wdata_d = x_full[DW-1:0];

    wp_d         = wp_q;
    sum_prev_d   = sum_prev_q;
    fill_d       = fill_q;
    out_valid_d  = 1'b0;
    data_out_d   = data_out_q;

    if (bus.clear) begin
      wp_d       = '0;
      sum_prev_d = '0;
      fill_d     = '0;
    end else if (bus.in_valid) begin
      out_valid_d = 1'b1;
      data_out_d  = x_full[DW-1:0];
      sum_prev_d  = bus.sum_in;
      wp_d        = (wp_q == WPW'(N - 1)) ? '0 : wp_q + 1'b1;
      if (fill_q != FW'(N)) begin
        fill_d = fill_q + 1'b1;
      end
    end

    warm_d = (fill_d == FW'(N));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q        <= '0;
      sum_prev_q  <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      warm_q      <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      sum_prev_q  <= sum_prev_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      warm_q      <= warm_d;
    end
  end

  // History is deliberately unreset; fill masks stale entries after reset/clear.
  always_ff @(posedge clk) begin
    if (accept) begin
      hist_q[wp_q] <= hist_wdata_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.warm      = warm_q;

`ifdef MIF_RANGE_CHECK_EN
  logic err_q, err_d;
  logic range_bad;

  // As a signed SW-bit value, x is in [0, 2^DW-1] exactly when all bits above DW-1 are zero.
  always_comb begin
    range_bad = |x_full[SW-1:DW];
    err_d     = err_q;
    if (bus.clear) begin
      err_d = 1'b0;
    end else if (accept && range_bad) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_hi;
  assign unused_hi = ^x_full[SW-1:DW];
  assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_mean_inverse_filter.sv
// Bench for mean_inverse_filter: samples are generated, windowed by a reference
// moving-sum model, fed to the DUT and the recovered samples compared to the originals.
module tb_mean_inverse_filter;
  localparam int unsigned N  = 60;
  localparam int unsigned DW = 24;
  localparam int unsigned SW = 30;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [DW-1:0] xs[$];

  mean_inverse_filter_if #(.DW(DW), .SW(SW)) bus ();

  mean_inverse_filter #(.N(N), .DW(DW), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: push a new sample and return the sum of the last N samples (zeros before start).
  function automatic logic [SW-1:0] push_sample(input logic [DW-1:0] x);
    logic [SW-1:0] acc;
    xs.push_back(x);
    if (xs.size() > N) void'(xs.pop_front());
    acc = '0;
    foreach (xs[i]) acc = acc + SW'(xs[i]);
    return acc;
  endfunction

  task automatic drive(input logic v, input logic c, input logic [SW-1:0] s);
    @(negedge clk);
    bus.in_valid = v;
    bus.clear    = c;
    bus.sum_in   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    bus.sum_in   = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    xs.delete();
  endtask

  task automatic test_reset();
    #12;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.data_out !== '0) begin bad++; $display("FAIL reset_data_out got=%h exp=0", bus.data_out); end
    total++; if (bus.warm !== 1'b0) begin bad++; $display("FAIL reset_warm got=%b exp=0", bus.warm); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_first_beats();
    logic [SW-1:0] sums [3];
    logic [DW-1:0] exp_x [3];
    sums  = '{30'd5, 30'd12, 30'd12};
    exp_x = '{24'd5, 24'd7, 24'd0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, sums[i]);
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL first_valid[%0d] got=%b exp=1", i, bus.out_valid); end
      total++; if (bus.data_out !== exp_x[i]) begin bad++; $display("FAIL first_data[%0d] got=%0d exp=%0d", i, bus.data_out, exp_x[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 30'd999);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL first_idle_valid[%0d] got=%b exp=0", i, bus.out_valid); end
      total++; if (bus.data_out !== 24'd0) begin bad++; $display("FAIL first_idle_hold[%0d] got=%0d exp=0", i, bus.data_out); end
    end
  endtask

  task automatic test_sawtooth();
    logic [DW-1:0] x;
    logic [SW-1:0] s;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      x = DW'(n % 101);
      s = push_sample(x);
      drive(1'b1, 1'b0, s);
      total++; if (bus.out_valid !== 1'b1 || bus.data_out !== x) begin
        bad++; $display("FAIL saw_data[%0d] got=%b/%0d exp=1/%0d", n, bus.out_valid, bus.data_out, x); end
      total++; if (bus.warm !== (n + 1 >= N)) begin bad++; $display("FAIL saw_warm[%0d] got=%b exp=%b", n, bus.warm, (n + 1 >= N)); end
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL saw_err[%0d] got=%b exp=0", n, bus.err); end
    end
  endtask

  task automatic test_wrap();
    logic [SW-1:0] s;
    do_reset();
    for (int n = 0; n < 125; n++) begin
      s = push_sample(24'd1000);
      drive(1'b1, 1'b0, s);
      total++; if (bus.data_out !== 24'd1000) begin bad++; $display("FAIL wrap_data[%0d] got=%0d exp=1000", n, bus.data_out); end
      total++; if (bus.warm !== (n + 1 >= N)) begin bad++; $display("FAIL wrap_warm[%0d] got=%b exp=%b", n, bus.warm, (n + 1 >= N)); end
    end
    total++; if (s !== 30'd60000) begin bad++; $display("FAIL wrap_model_sum got=%0d exp=60000", s); end
  endtask

  task automatic test_gapped(input bit rand_data);
    logic [DW-1:0] x, last_x;
    logic [SW-1:0] s;
    int n;
    int cycles;
    do_reset();
    n = 0; cycles = 0; last_x = '0;
    while (n < 300 && cycles < 3000) begin
      cycles++;
      if ($urandom_range(0, 1) == 1) begin
        x = rand_data ? DW'($urandom) : DW'(n % 101);
        s = push_sample(x);
        drive(1'b1, 1'b0, s);
        total++; if (bus.out_valid !== 1'b1 || bus.data_out !== x) begin
          bad++; $display("FAIL gap_data[%0d] got=%b/%0h exp=1/%0h", n, bus.out_valid, bus.data_out, x); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL gap_err[%0d] got=%b exp=0", n, bus.err); end
        last_x = x;
        n++;
      end else begin
        drive(1'b0, 1'b0, DW'($urandom));
        total++; if (bus.out_valid !== 1'b0 || bus.data_out !== last_x) begin
          bad++; $display("FAIL gap_hold[%0d] got=%b/%0h exp=0/%0h", n, bus.out_valid, bus.data_out, last_x); end
      end
      total++; if (bus.warm !== (n >= N)) begin bad++; $display("FAIL gap_warm[%0d] got=%b exp=%b", n, bus.warm, (n >= N)); end
    end
    total++; if (n < 300) begin bad++; $display("FAIL gap_budget got=%0d exp=300", n); end
  endtask

  task automatic test_clear();
    logic [DW-1:0] x;
    logic [SW-1:0] s;
    do_reset();
    for (int n = 0; n < 75; n++) begin
      x = DW'(n % 101);
      s = push_sample(x);
      drive(1'b1, 1'b0, s);
    end
    total++; if (bus.warm !== 1'b1) begin bad++; $display("FAIL clr_prewarm got=%b exp=1", bus.warm); end
    s = push_sample(DW'(75));
    drive(1'b1, 1'b1, s);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.warm !== 1'b0) begin bad++; $display("FAIL clr_warm got=%b exp=0", bus.warm); end
    total++; if (bus.data_out !== 24'd74) begin bad++; $display("FAIL clr_hold got=%0d exp=74", bus.data_out); end
    xs.delete();
    for (int k = 1; k <= 80; k++) begin
      x = DW'((75 + k) % 101);
      s = push_sample(x);
      drive(1'b1, 1'b0, s);
      total++; if (bus.out_valid !== 1'b1 || bus.data_out !== x) begin
        bad++; $display("FAIL clr_data[%0d] got=%b/%0d exp=1/%0d", k, bus.out_valid, bus.data_out, x); end
      total++; if (bus.warm !== (k >= N)) begin bad++; $display("FAIL clr_rewarm[%0d] got=%b exp=%b", k, bus.warm, (k >= N)); end
    end
  endtask

  task automatic test_async_reset();
    logic [SW-1:0] s;
    do_reset();
    for (int n = 0; n < 70; n++) begin
      s = push_sample(DW'(n + 3));
      drive(1'b1, 1'b0, s);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.data_out !== '0 || bus.warm !== 1'b0 || bus.err !== 1'b0) begin
      bad++; $display("FAIL arst_outputs got=%b/%0d/%b/%b exp=0/0/0/0", bus.out_valid, bus.data_out, bus.warm, bus.err); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    xs.delete();
    s = push_sample(24'd7);
    drive(1'b1, 1'b0, s);
    total++; if (bus.data_out !== 24'd7) begin bad++; $display("FAIL arst_first got=%0d exp=7", bus.data_out); end
  endtask

  task automatic test_range();
    logic exp_err;
`ifdef MIF_RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    drive(1'b1, 1'b0, 30'd10);
    total++; if (bus.data_out !== 24'd10 || bus.err !== 1'b0) begin
      bad++; $display("FAIL rng_first got=%0d/%b exp=10/0", bus.data_out, bus.err); end
    drive(1'b1, 1'b0, 30'd4);
    total++; if (bus.data_out !== 24'hFFFFFA) begin bad++; $display("FAIL rng_trunc got=%h exp=fffffa", bus.data_out); end
    total++; if (bus.err !== exp_err) begin bad++; $display("FAIL rng_err got=%b exp=%b", bus.err, exp_err); end
    drive(1'b0, 1'b0, '0);
    total++; if (bus.err !== exp_err) begin bad++; $display("FAIL rng_sticky got=%b exp=%b", bus.err, exp_err); end
    drive(1'b0, 1'b1, '0);
    total++; if (bus.err !== 1'b0 || bus.out_valid !== 1'b0 || bus.data_out !== 24'hFFFFFA) begin
      bad++; $display("FAIL rng_clear got=%b/%b/%h exp=0/0/fffffa", bus.err, bus.out_valid, bus.data_out); end
    drive(1'b1, 1'b0, 30'd9);
    total++; if (bus.data_out !== 24'd9) begin bad++; $display("FAIL rng_restart got=%0d exp=9", bus.data_out); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.sum_in   = '0;
    test_reset();
    test_first_beats();
    test_sawtooth();
    test_wrap();
    test_gapped(1'b0);
    test_gapped(1'b1);
    test_clear();
    test_async_reset();
    test_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
